pc_fetch_unit: RTL and testbench

Instruction fetch stage of the single-cycle MIPS core, directly upstream of the instruction ROM. It holds the program counter and drives the ROM word address. It decodes the control-transfer opcodes of the returned instruction and computes next-PC for sequential, beq/bne, j/jal and jr flow. It has no branch delay slot. Its outputs are an error flag and a retired-fetch counter.

---
 rtl/pc_fetch_unit.sv | 115 +++++++++++
 tb/tb_pc_fetch_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Instruction fetch stage: holds the PC, drives the ROM word address and resolves
// next-PC for sequential, beq/bne, j/jal and jr flow, with a sticky fault on bad PCs.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned ROM_DEPTH = 21
) (
  input  logic              clk,
  input  logic              resetn,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_inst,
  input  logic              stall,
  input  logic              rs_eq_rt,
  input  logic [31:0]       rs_value,
  output logic [31:0]       pc,
  output logic [31:0]       inst,
  output logic              inst_valid,
  output logic [31:0]       link_addr,
  output logic              fetch_err,
  output logic [31:0]       fetch_cnt
);

  localparam logic [5:0] OpSpecial = 6'b000000;
  localparam logic [5:0] OpJ       = 6'b000010;
  localparam logic [5:0] OpJal     = 6'b000011;
  localparam logic [5:0] OpBeq     = 6'b000100;
  localparam logic [5:0] OpBne     = 6'b000101;
  localparam logic [5:0] FunctJr   = 6'b001000;

  typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] cnt_q, cnt_d;
  logic        err_q, err_d;

  logic [31:0] word_idx;
  logic        range_ok;
  logic [31:0] pc_plus4;
  logic [31:0] br_target;
  logic [31:0] next_pc;
  logic [5:0]  op;
  logic [5:0]  funct;

  assign word_idx = 32'(pc_q[ADDR_W+1:2]);
  assign range_ok = (pc_q[1:0] == 2'b00) && (pc_q[31:ADDR_W+2] == '0) &&
                    (word_idx < ROM_DEPTH);

  assign op        = rom_inst[31:26];
  assign funct     = rom_inst[5:0];
  assign pc_plus4  = pc_q + 32'd4;
  assign br_target = pc_plus4 + {{14{rom_inst[15]}}, rom_inst[15:0], 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    case (op)
      OpBeq:       if (rs_eq_rt)  next_pc = br_target;
      OpBne:       if (!rs_eq_rt) next_pc = br_target;
      OpJ, OpJal:  next_pc = {pc_plus4[31:28], rom_inst[25:0], 2'b00};
      OpSpecial:   if (funct == FunctJr) next_pc = rs_value;
      default:     next_pc = pc_plus4;
    endcase
  end

  // A bad PC faults on the next edge whatever stall says; HALT is left only by reset.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (range_ok) begin
          state_d = StRun;
        end else begin
          state_d = StHalt;
          err_d   = 1'b1;
        end
      end
      StRun: begin
        if (!range_ok) begin
          state_d = StHalt;
          err_d   = 1'b1;
        end else if (!stall) begin
          pc_d  = next_pc;
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = StHalt;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      cnt_q   <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign inst_valid = (state_q == StRun) && range_ok;
  assign inst       = inst_valid ? rom_inst : 32'h0;
  assign rom_addr   = pc_q[ADDR_W+1:2];
  assign pc         = pc_q;
  assign link_addr  = pc_plus4;
  assign fetch_err  = err_q;
  assign fetch_cnt  = cnt_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed flow scenarios plus randomized
// instruction streams compared against a behavioural fetch model.
module tb_pc_fetch_unit;

  localparam int unsigned AddrW    = 5;
  localparam int unsigned RomDepth = 21;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic [AddrW-1:0] rom_addr;
  logic [31:0]      rom_inst = 32'h0;
  logic             stall = 1'b0;
  logic             rs_eq_rt = 1'b0;
  logic [31:0]      rs_value = 32'h0;
  logic [31:0]      pc, inst, link_addr, fetch_cnt;
  logic             inst_valid, fetch_err;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: phase 0 = waiting one cycle after reset, 1 = running, 2 = halted
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  bit          m_err;
  int          m_phase;

  pc_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .ADDR_W   (AddrW),
    .ROM_DEPTH(RomDepth)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .rom_addr  (rom_addr),
    .rom_inst  (rom_inst),
    .stall     (stall),
    .rs_eq_rt  (rs_eq_rt),
    .rs_value  (rs_value),
    .pc        (pc),
    .inst      (inst),
    .inst_valid(inst_valid),
    .link_addr (link_addr),
    .fetch_err (fetch_err),
    .fetch_cnt (fetch_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit ref_ok(input logic [31:0] p);
    return (p % 4 == 0) && (p < RomDepth * 4);
  endfunction

  function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [31:0] i,
                                           input bit eq, input logic [31:0] rsv);
    int unsigned op;
    int signed   off;
    logic [31:0] seq;
    op  = i >> 26;
    off = $signed(i[15:0]);
    seq = p + 32'd4;
    case (op)
      4: return eq  ? seq + 32'(off * 4) : seq;
      5: return !eq ? seq + 32'(off * 4) : seq;
      2, 3: return (seq & 32'hF000_0000) | ((i & 32'h03FF_FFFF) << 2);
      0: return ((i & 32'h3F) == 32'h8) ? rsv : seq;
      default: return seq;
    endcase
  endfunction

  task automatic check_outputs();
    bit valid;
    valid = (m_phase == 1) && ref_ok(m_pc);
    check_eq("pc", pc, m_pc);
    check_eq("rom_addr", 32'(rom_addr), (m_pc / 4) % 32);
    check_eq("link_addr", link_addr, m_pc + 32'd4);
    check_eq("fetch_cnt", fetch_cnt, m_cnt);
    check_eq("fetch_err", 32'(fetch_err), 32'(m_err));
    check_eq("inst_valid", 32'(inst_valid), 32'(valid));
    check_eq("inst", inst, valid ? rom_inst : 32'h0);
  endtask

  // Present one ROM word and operands for a cycle, check, then advance the model.
  task automatic step(input logic [31:0] i, input bit s, input bit e, input logic [31:0] r);
    logic [31:0] npc;
    rom_inst = i;
    stall    = s;
    rs_eq_rt = e;
    rs_value = r;
    #1;
    check_outputs();
    npc = ref_next(m_pc, i, e, r);
    @(posedge clk);
    #1;
    if (m_phase == 0) begin
      m_phase = ref_ok(m_pc) ? 1 : 2;
      m_err   = !ref_ok(m_pc);
    end else if (m_phase == 1) begin
      if (!ref_ok(m_pc)) begin
        m_phase = 2;
        m_err   = 1'b1;
      end else if (!s) begin
        m_pc  = npc;
        m_cnt = m_cnt + 32'd1;
      end
    end
  endtask

  task automatic do_reset();
    rom_inst = 32'h2402_0001;
    resetn   = 1'b0;
    #1;
    check_eq("rst_pc", pc, 32'h0);
    check_eq("rst_cnt", fetch_cnt, 32'h0);
    check_eq("rst_err", 32'(fetch_err), 32'h0);
    check_eq("rst_valid", 32'(inst_valid), 32'h0);
    check_eq("rst_inst", inst, 32'h0);
    m_pc    = 32'h0;
    m_cnt   = 32'h0;
    m_err   = 1'b0;
    m_phase = 0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  function automatic logic [31:0] gen_inst();
    int unsigned k;
    logic [31:0] off;
    k   = $urandom_range(0, 9);
    off = 32'($urandom_range(0, 10)) - 32'd5;
    case (k)
      4: return {6'b000100, 10'($urandom), off[15:0]};
      5: return {6'b000101, 10'($urandom), off[15:0]};
      6: return {6'b000010, 26'($urandom_range(0, 22))};
      7: return {6'b000011, 26'($urandom_range(0, 22))};
      8: return {6'b000000, 5'($urandom), 15'h0, 6'b001000};
      9: return $urandom;
      default: return {6'b001001, 26'($urandom)};
    endcase
  endfunction

  initial begin
    // Reset, idle cycle, then three sequential fetches
    do_reset();
    step(32'h2402_0001, 0, 0, 0);
    step(32'h2402_0001, 0, 0, 0);
    step(32'h2403_0001, 0, 0, 0);
    step(32'h2404_0001, 0, 0, 0);
    check_eq("seq_pc", pc, 32'h0C);
    check_eq("seq_cnt", fetch_cnt, 32'd3);
    // Branches taken / not taken
    step(32'h0800_0006, 0, 0, 0);
    step(32'h10A0_0005, 0, 1, 0);
    check_eq("beq_taken", pc, 32'h30);
    step(32'h0800_0006, 0, 0, 0);
    step(32'h10A0_0005, 0, 0, 0);
    check_eq("beq_not_taken", pc, 32'h1C);
    step(32'h14A0_0005, 0, 0, 0);
    check_eq("bne_taken", pc, 32'h34);
    // Jumps, jal link, jr
    step(32'h0800_0010, 0, 0, 0);
    check_eq("j_pc", pc, 32'h40);
    step(32'h0800_0003, 0, 0, 0);
    check_eq("j_back", pc, 32'h0C);
    step(32'h0C00_0013, 0, 0, 0);
    step(32'h0800_0003, 0, 0, 0);
    check_eq("j_from_4c", pc, 32'h0C);
    step(32'h0020_0008, 0, 0, 32'h14);
    check_eq("jr_pc", pc, 32'h14);
    // Stall for three cycles at 0x20
    step(32'h0800_0008, 0, 0, 0);
    for (int c = 0; c < 3; c++) step(32'h2402_0001, 1, 0, 0);
    check_eq("stall_pc", pc, 32'h20);
    step(32'h2402_0001, 0, 0, 0);
    check_eq("unstall_pc", pc, 32'h24);
    // Out of range jump, then halt holds
    step(32'h0800_0015, 0, 0, 0);
    step(32'h2402_0001, 0, 0, 0);
    check_eq("halt_err", 32'(fetch_err), 32'h1);
    step(32'h0800_0003, 0, 0, 0);
    check_eq("halt_pc", pc, 32'h54);
    do_reset();
    // Same fault with stall held
    step(32'h2402_0001, 0, 0, 0);
    step(32'h0800_0015, 0, 0, 0);
    step(32'h2402_0001, 1, 0, 0);
    check_eq("halt_stall_err", 32'(fetch_err), 32'h1);
    do_reset();
    // Misaligned jr target
    step(32'h2402_0001, 0, 0, 0);
    step(32'h0020_0008, 0, 0, 32'h6);
    step(32'h2402_0001, 0, 0, 0);
    check_eq("jr_misaligned_err", 32'(fetch_err), 32'h1);
    check_eq("jr_misaligned_pc", pc, 32'h6);
    // Reset mid-operation at 0x40
    do_reset();
    step(32'h2402_0001, 0, 0, 0);
    step(32'h0800_0010, 0, 0, 0);
    check_eq("pre_reset_pc", pc, 32'h40);
    do_reset();

    // Randomized instruction streams
    for (int ep = 0; ep < 25; ep++) begin
      do_reset();
      for (int c = 0; c < 40; c++) begin
        logic [31:0] rsv;
        rsv = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 90))
                                           : 32'($urandom_range(0, 20) * 4);
        step(gen_inst(), $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), rsv);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
